// File: rtl/shift_left_seq.sv
// Multi-cycle logical-left shifter (SLL/SLLI) with valid/ready on both sides.
// The operand moves at most STEP bits per cycle; flush_i aborts any operation.
module shift_left_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rd_o,
  output logic             busy_o
);

  // state | meaning
  // IDLE  | waiting for a request, ready_o=1
  // SHIFT | shifting by min(rem, STEP) each cycle
  // DONE  | result on rd_o with valid_o=1 until ready_i
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // STEP may equal WIDTH, which needs one bit more than the shift-amount field.
  localparam logic [SHAMT_W:0] STEP_W = STEP[SHAMT_W:0];

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   rem_ext, step_k, rem_left;
  logic               unused_rs2_hi;

  assign shamt         = rs2_i[SHAMT_W-1:0];
  assign unused_rs2_hi = ^rs2_i[WIDTH-1:SHAMT_W];
  assign rem_ext       = {1'b0, rem_q};
  assign step_k        = (rem_ext < STEP_W) ? rem_ext : STEP_W;
  assign rem_left      = rem_ext - step_k;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !flush_i) begin
          data_d  = rs1_i;
          rem_d   = shamt;
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q << step_k;
        rem_d  = rem_left[SHAMT_W-1:0];
        if (rem_left == '0) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over every transition; the data register may keep stale bits.
    if (flush_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end
  end

  assign rd_o   = data_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: scoreboard of expected result and latency
// pushed on request acceptance, popped when valid_o rises.
module tb_shift_left_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] rd_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rd_q[$];
  int          exp_lat_q[$];

  shift_left_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .rd_o(rd_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result, optionally stall ready_i, then retire it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] er;
    int el;
    @(negedge clk_i);
    chk("ready_before_req", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; rs1_i = a; rs2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    exp_rd_q.push_back(a << b[4:0]);
    exp_lat_q.push_back((int'(b[4:0]) + 3) / 4);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    er = exp_rd_q.pop_front();
    el = exp_lat_q.pop_front();
    chk("latency", lat, el);
    chk("rd", rd_o, er);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_rd", rd_o, er);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("ret_ready", {31'd0, ready_o}, 32'd1);
    chk("ret_busy", {31'd0, busy_o}, 32'd0);
    chk("ret_valid", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rd", rd_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    run_op(32'hDEADBEEF, 32'h0, 0);
    run_op(32'h12345678, 32'd4, 0);
    run_op(32'h12345678, 32'h25, 0);
    run_op(32'h00000001, 32'd31, 0);
    run_op(32'hFFFFFFFF, 32'd31, 0);
    run_op(32'hA5A5A5A5, 32'd8, 5);
    run_op(32'h0F0F0F0F, 32'd13, 1);

    // Flush on the third SHIFT cycle of a long shift.
    @(negedge clk_i);
    valid_i = 1'b1; rs1_i = 32'h1; rs2_i = 32'd31;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fl_novalid", {31'd0, valid_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    chk("fl_busy_pre", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("fl_busy", {31'd0, busy_o}, 32'd0);
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_ready", {31'd0, ready_o}, 32'd1);
    run_op(32'h3, 32'd1, 0);

    // Flush together with a request in IDLE drops the request.
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; rs1_i = 32'h55; rs2_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("fl_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("fl_idle_valid", {31'd0, valid_o}, 32'd0);

    // Asynchronous reset between clock edges mid-SHIFT.
    @(negedge clk_i);
    valid_i = 1'b1; rs1_i = 32'h80; rs2_i = 32'd20;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_o}, 32'd0);
    chk("ar_busy", {31'd0, busy_o}, 32'd0);
    chk("ar_rd", rd_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("ar_ready", {31'd0, ready_o}, 32'd1);
    run_op(32'hCAFEF00D, 32'd9, 0);

    for (int i = 0; i < 8; i++) run_op($urandom, $urandom, $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
